// File: rtl/rom_seq_ctrl_if.sv
// Control/status bundle between a ROM address sequencer and whoever drives it.
// No valid/ready handshake: key_flag and step_flag are single-cycle pulses sampled on every
// rising sys_clk edge, run_en and dir are levels, and addr/hold_vec/tick are registered.
interface rom_seq_ctrl_if #(
   parameter int ADDR_W   = 8,
   parameter int NUM_KEYS = 2
);
   logic [NUM_KEYS-1:0] key_flag;
   logic                run_en;
   logic                step_flag;
   logic                dir;
   logic [ADDR_W-1:0]   addr;
   logic [NUM_KEYS-1:0] hold_vec;
   logic                tick;

   modport master (
      output key_flag, run_en, step_flag, dir,
      input  addr, hold_vec, tick
   );

   modport slave (
      input  key_flag, run_en, step_flag, dir,
      output addr, hold_vec, tick
   );
endinterface

// File: rtl/rom_seq_ctrl.sv
// ROM address sequencer: timed auto-advance, paused single-stepping and
// per-key preset holds, with wrap between ADDR_MIN and ADDR_MAX.
module rom_seq_ctrl #(
   parameter int                         ADDR_W   = 8,
   parameter logic [23:0]                TICK_MAX = 24'd9_999_999,
   parameter int                         NUM_KEYS = 2,
   parameter logic [NUM_KEYS*ADDR_W-1:0] PRESETS  = {8'd199, 8'd99},
   parameter logic [ADDR_W-1:0]          ADDR_MIN = '0,
   parameter logic [ADDR_W-1:0]          ADDR_MAX = {ADDR_W{1'b1}}
) (
   input logic           sys_clk,
   input logic           sys_rst_n,
   rom_seq_ctrl_if.slave bus
);

   localparam int                CNT_W = $bits(TICK_MAX);
   localparam logic [ADDR_W:0]   SPAN  = {1'b0, ADDR_MAX} - {1'b0, ADDR_MIN};

   logic [CNT_W-1:0]    cnt;
   logic [NUM_KEYS-1:0] key_sel;
   logic [ADDR_W-1:0]   preset_addr;
   logic [ADDR_W-1:0]   adv_addr;
   logic [ADDR_W-1:0]   offs;
   logic                key_evt;
   logic                key_hit_held;
   logic                hold_active;
   logic                in_range;
   logic                term;
   logic                auto_adv;
   logic                step_adv;

   assign key_evt      = |bus.key_flag;
   assign hold_active  = |bus.hold_vec;
   assign key_hit_held = |(key_sel & bus.hold_vec);
   assign term         = (cnt == TICK_MAX);
   assign auto_adv     = bus.run_en && !hold_active && term && !key_evt;
   assign step_adv     = !bus.run_en && !hold_active && bus.step_flag && !key_evt;

   // Offset from ADDR_MIN exceeds the span for any address below ADDR_MIN or above ADDR_MAX.
   assign offs     = bus.addr - ADDR_MIN;
   assign in_range = ({1'b0, offs} <= SPAN);

   // Isolate the lowest set key bit so simultaneous presses resolve to the lowest index.
   always_comb begin
      key_sel     = bus.key_flag & ~(bus.key_flag - NUM_KEYS'(1));
      preset_addr = ADDR_MIN;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (key_sel[k]) preset_addr = PRESETS[k*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      adv_addr = bus.addr;
      if (!in_range) begin
         adv_addr = bus.dir ? ADDR_MAX : ADDR_MIN;
      end else if (bus.dir) begin
         adv_addr = (bus.addr == ADDR_MIN) ? ADDR_MAX : bus.addr - ADDR_W'(1);
      end else begin
         adv_addr = (bus.addr == ADDR_MAX) ? ADDR_MIN : bus.addr + ADDR_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bus.addr     <= ADDR_MIN;
         bus.hold_vec <= '0;
         bus.tick     <= 1'b0;
         cnt          <= '0;
      end else begin
         bus.tick <= auto_adv;
         if (key_evt) begin
            cnt <= '0;
            if (key_hit_held) begin
               bus.hold_vec <= '0;
            end else begin
               bus.hold_vec <= key_sel;
               bus.addr     <= preset_addr;
            end
         end else if (hold_active) begin
            cnt <= '0;
         end else begin
            // Counter only moves while running; a pause freezes it mid-period.
            if (bus.run_en) cnt <= term ? '0 : cnt + CNT_W'(1);
            if (auto_adv || step_adv) bus.addr <= adv_addr;
         end
      end
   end

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Directed bench for rom_seq_ctrl with a short tick period and a narrow wrap window [2,5].
module tb_rom_seq_ctrl;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   rom_seq_ctrl_if #(.ADDR_W(4), .NUM_KEYS(2)) bus ();

   rom_seq_ctrl #(
      .ADDR_W   (4),
      .TICK_MAX (24'd3),
      .NUM_KEYS (2),
      .PRESETS  ({4'd5, 4'd3}),
      .ADDR_MIN (4'd2),
      .ADDR_MAX (4'd5)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus.slave)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [1:0] key;
      logic       run;
      logic       step;
      logic       dir;
      logic [3:0] addr;
      logic [1:0] hold;
      logic       tick;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [1:0] key, input logic run, input logic step,
                               input logic dir, input logic [3:0] addr, input logic [1:0] hold,
                               input logic tick);
      vec_t v;
      v.key = key; v.run = run; v.step = step; v.dir = dir;
      v.addr = addr; v.hold = hold; v.tick = tick;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int idx, input logic [7:0] got,
                        input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s #%0d: got %0d, want %0d", name, idx, got, exp);
      end
   endtask

   task automatic apply_row(input vec_t v, input int idx);
      bus.key_flag  = v.key;
      bus.run_en    = v.run;
      bus.step_flag = v.step;
      bus.dir       = v.dir;
      @(posedge sys_clk);
      #1;
      check("addr", idx, 8'(bus.addr), 8'(v.addr));
      check("hold_vec", idx, 8'(bus.hold_vec), 8'(v.hold));
      check("tick", idx, 8'(bus.tick), 8'(v.tick));
   endtask

   task automatic check_reset(input int idx);
      check("rst_addr", idx, 8'(bus.addr), 8'd2);
      check("rst_hold", idx, 8'(bus.hold_vec), 8'd0);
      check("rst_tick", idx, 8'(bus.tick), 8'd0);
   endtask

   initial begin
      logic [3:0] nx[4];
      logic [3:0] cur;
      vec_t       v;

      // Auto-advance up from reset: 2,3,4,5,2 at four-cycle intervals.
      nx = '{4'd3, 4'd4, 4'd5, 4'd2};
      cur = 4'd2;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 3; c++) add(2'b00, 1, 0, 0, cur, 2'b00, 0);
         add(2'b00, 1, 0, 0, nx[s], 2'b00, 1);
         cur = nx[s];
      end
      // Key 0 hold for 20 cycles, release, full period wait before next step.
      add(2'b01, 1, 0, 0, 4'd3, 2'b01, 0);
      for (int i = 0; i < 20; i++) add(2'b00, 1, 0, 0, 4'd3, 2'b01, 0);
      add(2'b01, 1, 0, 0, 4'd3, 2'b00, 0);
      for (int i = 0; i < 3; i++) add(2'b00, 1, 0, 0, 4'd3, 2'b00, 0);
      add(2'b00, 1, 0, 0, 4'd4, 2'b00, 1);
      // Hold switch, then both keys on a terminal count: key 0 wins, no advance, no tick.
      add(2'b01, 1, 0, 0, 4'd3, 2'b01, 0);
      add(2'b10, 1, 0, 0, 4'd5, 2'b10, 0);
      add(2'b10, 1, 0, 0, 4'd5, 2'b00, 0);
      for (int i = 0; i < 3; i++) add(2'b00, 1, 0, 0, 4'd5, 2'b00, 0);
      add(2'b11, 1, 0, 0, 4'd3, 2'b01, 0);
      add(2'b01, 1, 0, 0, 4'd3, 2'b00, 0);
      // Counter to 2, pause and step down through the wrap, resume: one cycle left.
      add(2'b00, 1, 0, 0, 4'd3, 2'b00, 0);
      add(2'b00, 1, 0, 0, 4'd3, 2'b00, 0);
      add(2'b00, 0, 1, 1, 4'd2, 2'b00, 0);
      add(2'b00, 0, 0, 1, 4'd2, 2'b00, 0);
      add(2'b00, 0, 1, 1, 4'd5, 2'b00, 0);
      add(2'b00, 0, 1, 1, 4'd4, 2'b00, 0);
      add(2'b00, 1, 1, 1, 4'd4, 2'b00, 0);
      add(2'b00, 1, 0, 1, 4'd3, 2'b00, 1);
      // Step ignored during a paused hold; after release a step up wraps 5 -> 2.
      add(2'b10, 0, 0, 0, 4'd5, 2'b10, 0);
      add(2'b00, 0, 1, 0, 4'd5, 2'b10, 0);
      add(2'b10, 0, 0, 0, 4'd5, 2'b00, 0);
      add(2'b00, 0, 1, 0, 4'd2, 2'b00, 0);
      // Build a hold with the counter previously at 2, for the async reset check.
      add(2'b00, 1, 0, 0, 4'd2, 2'b00, 0);
      add(2'b00, 1, 0, 0, 4'd2, 2'b00, 0);
      add(2'b01, 1, 0, 0, 4'd3, 2'b01, 0);

      bus.key_flag  = '0;
      bus.run_en    = 1'b1;
      bus.step_flag = 1'b0;
      bus.dir       = 1'b0;
      #1 sys_rst_n = 1'b0;
      #1 check_reset(0);
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i], i);

      // Asynchronous reset mid-hold: outputs clear before any clock edge.
      #2 sys_rst_n = 1'b0;
      #1 check_reset(1);
      bus.key_flag = '0;
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;

      // Hold discarded: auto-advance resumes from ADDR_MIN with a full period.
      v = '{key: 2'b00, run: 1'b1, step: 1'b0, dir: 1'b0, addr: 4'd2, hold: 2'b00, tick: 1'b0};
      for (int i = 0; i < 3; i++) apply_row(v, 100 + i);
      v.addr = 4'd3;
      v.tick = 1'b1;
      apply_row(v, 103);

      // Reset while tick is high clears it at once.
      #2 sys_rst_n = 1'b0;
      #1 check_reset(2);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
